// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: one 1-bit ALU slice stepped LSB first over WIDTH bits.
// Optional `define BSALU_ABORT_EN adds an abort input that cancels a running operation.
module bit_serial_alu_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef BSALU_ABORT_EN
    input  logic             abort,
`endif
    input  logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, res_sh_q;
    logic [3:0]       ctl_q;
    logic             carry_q;
    logic [CW-1:0]    count_q;
    logic             lt_q;

    logic             abort_req;
    logic             is_slt, is_addsub, last;
    logic [1:0]       op;
    logic             sa, sb, sum, cout, slice_out, res_bit;
    logic [WIDTH-1:0] res_next;

`ifdef BSALU_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Slice controls; SLT reuses the subtract path and discards the per-bit results.
    assign is_slt    = (ctl_q == 4'b0111);
    assign is_addsub = (ctl_q == 4'b0010) || (ctl_q == 4'b0110);
    assign op        = is_slt ? 2'b10 : ctl_q[1:0];
    assign sa        = a_sh_q[0] ^ ctl_q[3];
    assign sb        = b_sh_q[0] ^ ctl_q[2];
    assign sum       = sa ^ sb ^ carry_q;
    assign cout      = (sa & sb) | (sa & carry_q) | (sb & carry_q);
    assign last      = (count_q == CW'(WIDTH - 1));

    always_comb begin
        slice_out = 1'b0;
        case (op)
            2'b00:   slice_out = sa & sb;
            2'b01:   slice_out = sa | sb;
            2'b10:   slice_out = sum;
            default: slice_out = 1'b0;  // Less input tied low
        endcase
    end

    assign res_bit  = is_slt ? 1'b0 : slice_out;
    assign res_next = {res_bit, res_sh_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StRun;
            StRun: begin
                if (abort_req)  state_d = StIdle;
                else if (last)  state_d = is_slt ? StFix : StDone;
            end
            StFix:  state_d = abort_req ? StIdle : StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StIdle:  busy = 1'b0;
            StRun,
            StFix:   busy = 1'b1;
            StDone: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    // Outputs are loaded on the edge entering StDone so they are valid while done is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            ctl_q    <= '0;
            carry_q  <= 1'b0;
            count_q  <= '0;
            lt_q     <= 1'b0;
            result   <= '0;
            zero     <= 1'b1;
            overflow <= 1'b0;
        end else if (state_q == StIdle && start) begin
            a_sh_q   <= a;
            b_sh_q   <= b;
            res_sh_q <= '0;
            ctl_q    <= alu_ctl;
            carry_q  <= alu_ctl[2];
            count_q  <= '0;
        end else if (state_q == StRun && !abort_req) begin
            a_sh_q   <= a_sh_q >> 1;
            b_sh_q   <= b_sh_q >> 1;
            res_sh_q <= res_next;
            carry_q  <= cout;
            count_q  <= count_q + CW'(1);
            if (last) begin
                // Signed less-than: sign of the difference corrected by MSB overflow.
                lt_q <= sum ^ (carry_q ^ cout);
                if (!is_slt) begin
                    result   <= res_next;
                    zero     <= (res_next == '0);
                    overflow <= is_addsub & (carry_q ^ cout);
                end
            end
        end else if (state_q == StFix && !abort_req) begin
            result   <= WIDTH'(lt_q);
            zero     <= ~lt_q;
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Self-checking bench for bit_serial_alu_ctrl at WIDTH=8 against a word-level reference model.
// Exercises the abort input when BSALU_ABORT_EN is defined.
module tb_bit_serial_alu_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic [3:0]   alu_ctl;
    logic [W-1:0] a, b;
    logic         busy, done, zero, overflow;
    logic [W-1:0] result;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bit_serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef BSALU_ABORT_EN
        .abort    (abort),
`endif
        .alu_ctl  (alu_ctl),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .overflow (overflow)
    );

    function automatic void model(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic ov);
        r  = '0;
        ov = 1'b0;
        case (c)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: begin
                r  = x + y;
                ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end
            4'b0110: begin
                r  = x - y;
                ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
            end
            4'b0111: r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
            4'b1100: r = ~(x | y);
            default: r = '0;
        endcase
    endfunction

    // Issues one op, returns cycles from accept to done and count of cycles where outputs moved early.
    task automatic run_op(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output int held_errs);
        logic [W-1:0] prev;
        logic         prev_z, prev_o;
        @(negedge clk);
        prev = result; prev_z = zero; prev_o = overflow;
        alu_ctl = c; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        held_errs = 0;
        @(negedge clk);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            if (result !== prev || zero !== prev_z || overflow !== prev_o) held_errs++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; abort = 1'b0; alu_ctl = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || zero !== 1'b1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b result=%h zero=%b ovf=%b, want 0 0 00 1 0",
                     busy, done, result, zero, overflow);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_directed;
        logic [3:0]   tc [9] = '{4'b0010, 4'b0110, 4'b0010, 4'b0111, 4'b0111,
                                 4'b0000, 4'b0001, 4'b1100, 4'b0011};
        logic [W-1:0] ta [9] = '{8'h7F, 8'h05, 8'hFF, 8'hFD, 8'h7F, 8'hF0, 8'hF0, 8'hF0, 8'hA5};
        logic [W-1:0] tb [9] = '{8'h01, 8'h05, 8'h01, 8'h02, 8'h80, 8'h3C, 8'h3C, 8'h3C, 8'h5A};
        logic [W-1:0] tr [9] = '{8'h80, 8'h00, 8'h00, 8'h01, 8'h00, 8'h30, 8'hFC, 8'h03, 8'h00};
        logic         to [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int lat, he, want_lat;
        for (int i = 0; i < 9; i++) begin
            run_op(tc[i], ta[i], tb[i], lat, he);
            want_lat = (tc[i] == 4'b0111) ? W + 2 : W + 1;
            checks++;
            if (lat != want_lat) begin
                failures++;
                $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, want_lat);
            end
            checks++;
            if (result !== tr[i] || zero !== (tr[i] == '0) || overflow !== to[i]) begin
                failures++;
                $display("FAIL dir%0d_result ctl=%b a=%h b=%h: got %h z=%b o=%b want %h z=%b o=%b",
                         i, tc[i], ta[i], tb[i], result, zero, overflow, tr[i], tr[i] == '0, to[i]);
            end
            checks++;
            if (he != 0) begin
                failures++;
                $display("FAIL dir%0d_held: outputs changed before done in %0d cycles, want 0", i, he);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || result !== tr[i]) begin
                failures++;
                $display("FAIL dir%0d_after_done: done=%b busy=%b result=%h want 0 0 %h",
                         i, done, busy, result, tr[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [3:0]   ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
        logic [3:0]   c;
        logic [W-1:0] x, y, er;
        logic         eo;
        int lat, he;
        for (int i = 0; i < 40; i++) begin
            c = ops[$urandom_range(0, 5)];
            x = W'($urandom);
            y = W'($urandom);
            model(c, x, y, er, eo);
            run_op(c, x, y, lat, he);
            checks++;
            if (lat != ((c == 4'b0111) ? W + 2 : W + 1) || he != 0 || result !== er
                || zero !== (er == '0) || overflow !== eo) begin
                failures++;
                $display("FAIL rand%0d ctl=%b a=%h b=%h: got %h z=%b o=%b lat=%0d held=%0d want %h z=%b o=%b",
                         i, c, x, y, result, zero, overflow, lat, he, er, er == '0, eo);
            end
        end
    endtask

    task automatic test_start_while_busy;
        int dones = 0;
        @(negedge clk);
        alu_ctl = 4'b0010; a = 8'h12; b = 8'h34; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (cyc == 3 || cyc == 5) begin
                alu_ctl = 4'b0001; a = 8'h0F; b = 8'hF0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        checks++;
        if (dones != 1 || result !== 8'h46) begin
            failures++;
            $display("FAIL start_while_busy: dones=%0d result=%h want 1 46", dones, result);
        end
    endtask

    task automatic test_back_to_back;
        int first = -1, second = -1;
        logic [W-1:0] r1 = '0;
        @(negedge clk);
        alu_ctl = 4'b0010; a = 8'h01; b = 8'h02; start = 1'b1;
        @(posedge clk);
        #1 a = 8'h0A; b = 8'h14;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (first < 0) begin
                    first = cyc; r1 = result;
                end else if (second < 0) begin
                    second = cyc;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (first != W + 1 || second != 2 * W + 3 || r1 !== 8'h03 || result !== 8'h1E) begin
            failures++;
            $display("FAIL back_to_back: dones at %0d,%0d results %h,%h want %0d,%0d 03,1e",
                     first, second, r1, result, W + 1, 2 * W + 3);
        end
    endtask

    task automatic test_reset_mid;
        int lat, he, dones = 0;
        run_op(4'b0001, 8'h11, 8'h22, lat, he);
        @(negedge clk);
        alu_ctl = 4'b0010; a = 8'h40; b = 8'h40; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || zero !== 1'b1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h zero=%b ovf=%b want 0 0 00 1 0",
                     busy, done, result, zero, overflow);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0 || result !== '0) begin
            failures++;
            $display("FAIL reset_mid_no_done: dones=%0d result=%h want 0 00", dones, result);
        end
        run_op(4'b0110, 8'h80, 8'h01, lat, he);
        checks++;
        if (lat != W + 1 || result !== 8'h7F || overflow !== 1'b1 || zero !== 1'b0) begin
            failures++;
            $display("FAIL after_reset_op: lat=%0d result=%h o=%b z=%b want %0d 7f 1 0",
                     lat, result, overflow, zero, W + 1);
        end
    endtask

`ifdef BSALU_ABORT_EN
    task automatic test_abort;
        int lat, he, dones = 0;
        run_op(4'b0001, 8'h50, 8'h05, lat, he);
        @(negedge clk);
        alu_ctl = 4'b1100; a = 8'h00; b = 8'h00; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_busy: busy=%b want 0", busy);
        end
        repeat (14) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0 || result !== 8'h55 || zero !== 1'b0) begin
            failures++;
            $display("FAIL abort_hold: dones=%0d result=%h z=%b want 0 55 0", dones, result, zero);
        end
        run_op(4'b0000, 8'hAA, 8'h0F, lat, he);
        checks++;
        if (lat != W + 1 || result !== 8'h0A) begin
            failures++;
            $display("FAIL abort_next_op: lat=%0d result=%h want %0d 0a", lat, result, W + 1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
`ifdef BSALU_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
